// File: rtl/domain_cfg_sync_pkg.sv
// Shared types and helpers for the domain configuration/reset front end.
// Optional build macro used by the top: DOMAIN_CFG_SYNC_LOCK_EN.
package domain_cfg_sync_pkg;

  localparam int NOC_CHIPID_SIZE = 8;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } rst_state_e;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/domain_cfg_sync_ch.sv
// One configuration channel: synchroniser chain, stability filter and commit register.
// Latency SYNC_STAGES+STABLE_CYCLES+2 edges from input change to cfg_o; no backpressure.
module domain_cfg_sync_ch
  import domain_cfg_sync_pkg::*;
#(
  parameter int WIDTH         = NOC_CHIPID_SIZE,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             reset_h_i,
  input  logic [WIDTH-1:0] cfg_i,
  input  logic             lock_i,
  output logic [WIDTH-1:0] cfg_o,
  output logic             valid_o,
  output logic             change_o,
  output logic             pending_o,
  output logic             lock_hit_o
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  cand_q;
  logic [CW-1:0]                     cnt_q;
  logic [WIDTH-1:0]                  cfg_q;
  logic                              valid_q;
  logic                              change_q;
  logic                              commit_cond;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge reset_h_i) begin
    if (reset_h_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cfg_i};
    end
  end

  // A first commit is always wanted, even when the value equals the reset value.
  assign commit_cond = (s == cand_q) && (cnt_q == CNT_MAX) &&
                       ((cand_q != cfg_q) || !valid_q);

  always_ff @(posedge clk_i or posedge reset_h_i) begin
    if (reset_h_i) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      change_q <= 1'b0;
      if (s != cand_q) begin
        cand_q <= s;
        cnt_q  <= '0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (commit_cond && !lock_i) begin
        cfg_q    <= cand_q;
        valid_q  <= 1'b1;
        change_q <= 1'b1;
      end
    end
  end

  assign cfg_o      = cfg_q;
  assign valid_o    = valid_q;
  assign change_o   = change_q;
  assign pending_o  = (cand_q != cfg_q);
  assign lock_hit_o = commit_cond && lock_i && (cand_q != cfg_q);

endmodule

// File: rtl/domain_cfg_sync.sv
// Config-word capture for NUM_CH async channels plus sequenced domain reset release.
// Build macro DOMAIN_CFG_SYNC_LOCK_EN freezes cfg_o once running and flags late changes.
module domain_cfg_sync
  import domain_cfg_sync_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int WIDTH         = NOC_CHIPID_SIZE,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int RESET_HOLD    = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_h_i,
  input  logic [NUM_CH*WIDTH-1:0] cfg_i,
  output logic [NUM_CH*WIDTH-1:0] cfg_o,
  output logic [NUM_CH-1:0]       cfg_valid_o,
  output logic [NUM_CH-1:0]       cfg_change_o,
  output logic                    cfg_stable_o,
  output logic                    domain_reset_n_o,
  output logic                    lock_err_o
);

  localparam int HW = cnt_width(RESET_HOLD);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD - 1);

  rst_state_e        state_q;
  logic [HW-1:0]     hold_q;
  logic              dom_rst_n_q;
  logic              lock_run;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] lock_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    domain_cfg_sync_ch #(
      .WIDTH         (WIDTH),
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk_i      (clk_i),
      .reset_h_i  (reset_h_i),
      .cfg_i      (cfg_i[c*WIDTH +: WIDTH]),
      .lock_i     (lock_run),
      .cfg_o      (cfg_o[c*WIDTH +: WIDTH]),
      .valid_o    (cfg_valid_o[c]),
      .change_o   (cfg_change_o[c]),
      .pending_o  (pending[c]),
      .lock_hit_o (lock_hit[c])
    );
  end

  always_ff @(posedge clk_i or posedge reset_h_i) begin
    if (reset_h_i) begin
      state_q     <= ST_RESET;
      hold_q      <= '0;
      dom_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (&cfg_valid_o) begin
            state_q <= ST_HOLD;
            hold_q  <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_q     <= ST_RUN;
            dom_rst_n_q <= 1'b1;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        ST_RUN:  dom_rst_n_q <= 1'b1;
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign domain_reset_n_o = dom_rst_n_q;
  assign cfg_stable_o     = (&cfg_valid_o) && !(|pending);

`ifdef DOMAIN_CFG_SYNC_LOCK_EN
  logic lock_err_q;

  assign lock_run = (state_q == ST_RUN);

  always_ff @(posedge clk_i or posedge reset_h_i) begin
    if (reset_h_i) begin
      lock_err_q <= 1'b0;
    end else if (|lock_hit) begin
      lock_err_q <= 1'b1;
    end
  end

  assign lock_err_o = lock_err_q;
`else
  assign lock_run = 1'b0;
  // lock_run is held low, so no channel can raise lock_hit: constant 0.
  assign lock_err_o = |lock_hit;
`endif

endmodule
